// File: rtl/cad_pkg.sv
// Shared constants for the register-file slice.
//   DATA_W_DEF : default register width
//   ADDR_W_DEF : default address width (DEPTH = 2**ADDR_W)
//   REG_ZERO   : address of the hard-wired zero register
package cad_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bitmap for the register file: one bit per register marking an
// outstanding write, used by decode to stall on hazards.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   clr                synchronous clear of every busy bit
//   wr_en, wr_addr     writeback ports; each enabled write clears its busy bit
//   rsv_en, rsv_addr   reservation; sets the busy bit (wins over a clearing write)
//   busy               current bitmap
//   pend_cnt           registered popcount of busy
module regfile_scoreboard
  import cad_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [2**ADDR_W-1:0]     busy,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  always_comb begin
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      wa[w] = wr_addr[w*ADDR_W +: ADDR_W];
    end
  end

  // Clears first, then the reservation, so a same-cycle reserve wins.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) busy_nxt[wa[w]] = 1'b0;
    end
    if (rsv_en && !(ZERO_REG != 0 && rsv_addr == ZERO_A)) busy_nxt[rsv_addr] = 1'b1;
    if (clr) busy_nxt = '0;
  end

  // Count is taken from the next state so pend_cnt always matches busy.
  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass and a
// hazard scoreboard. Sits between decode (reads) and writeback (writes).
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   clr                synchronous clear of all registers and busy bits
//   rd_addr/rd_data    NUM_RD combinational read ports (packed, port k at k*W)
//   rd_busy            busy bit of each read target
//   wr_en/wr_addr/wr_data  NUM_WR write ports, higher index has priority
//   rsv_en/rsv_addr    reserve a register for a multi-cycle op
//   pend_cnt           registered count of busy registers
module regfile_mp
  import cad_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [ADDR_W-1:0] wa   [NUM_WR];
  logic [DATA_W-1:0] wd   [NUM_WR];
  logic [ADDR_W-1:0] ra   [NUM_RD];
  logic [DATA_W-1:0] rdat [NUM_RD];
  logic              rhit [NUM_RD];
  logic [DEPTH-1:0]  busy;

  always_comb begin
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      wa[w] = wr_addr[w*ADDR_W +: ADDR_W];
      wd[w] = wr_data[w*DATA_W +: DATA_W];
    end
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      ra[r] = rd_addr[r*ADDR_W +: ADDR_W];
    end
  end

  // Ports are visited in ascending order, so the last NBA (highest index) wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && !(ZERO_REG != 0 && wa[w] == ZERO_A)) mem[wa[w]] <= wd[w];
      end
    end
  end

  // Bypass: the highest-index matching write overrides the array value.
  // The zero-register mask is applied last so it also covers bypassed data.
  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rdat[r] = mem[ra[r]];
      rhit[r] = 1'b0;
      if (BYPASS != 0 && !clr) begin
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && wa[w] == ra[r]) begin
            rdat[r] = wd[w];
            rhit[r] = 1'b1;
          end
        end
      end
      if (ZERO_REG != 0 && ra[r] == ZERO_A) rdat[r] = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_data[r*DATA_W +: DATA_W] = rdat[r];
      rd_busy[r] = busy[ra[r]] && !rhit[r];
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypassing instance plus a
// non-bypassing instance sharing the same stimulus. Expectations are queued
// when stimulus is driven and compared when outputs are sampled.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk, reset, clr;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data, rd_data_nb;
  logic [1:0]    rd_busy, rd_busy_nb;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic [AW:0]   pend_cnt, pend_cnt_nb;

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk(clk), .reset(reset), .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt)
  );

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)
  ) u_dut_nb (
    .clk(clk), .reset(reset), .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_RD, K_RDNB, K_BUSY, K_CNT} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int errors = 0;

  logic [31:0] mem_m [32];
  bit          busy_m [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input kind_e k, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = k; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD:    obs = rd_data[e.idx*DW +: DW];
        K_RDNB:  obs = rd_data_nb[e.idx*DW +: DW];
        K_BUSY:  obs = {31'd0, rd_busy[e.idx]};
        default: obs = {26'd0, pend_cnt};
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    wr_en = '0; rsv_en = 1'b0; clr = 1'b0;
  endtask

  task automatic edge_();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2; drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] a0, a1, w0, w1;
    logic [31:0] d0, d1, e;
    bit hit;
    int c;

    reset = 1'b0; idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    #2 reset = 1'b1;
    repeat (2) edge_();
    push("reset_cnt", K_CNT, 0, 32'd0);
    push("reset_rd0", K_RD, 0, 32'd0);
    settle();
    reset = 1'b0;
    edge_();

    // 1: all addresses read zero after reset
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      push("t1_rd0", K_RD, 0, 32'd0);
      push("t1_rd1", K_RD, 1, 32'd0);
      push("t1_busy0", K_BUSY, 0, 32'd0);
      push("t1_busy1", K_BUSY, 1, 32'd0);
      #1 drain();
    end
    push("t1_cnt", K_CNT, 0, 32'd0);
    drain();

    // 2: dual write to r5, higher port wins, bypassed and stored
    edge_();
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'h5555, 32'hAAAA};
    rd_addr = {5'd6, 5'd5};
    push("t2_byp", K_RD, 0, 32'h5555);
    push("t2_other", K_RD, 1, 32'd0);
    push("t2_nb_old", K_RDNB, 0, 32'd0);
    settle();
    edge_(); idle();
    push("t2_stored", K_RD, 0, 32'h5555);
    push("t2_nb_stored", K_RDNB, 0, 32'h5555);
    settle();

    // 3: r0 write and reserve are ignored
    edge_();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'hFFFF_FFFF};
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    push("t3_r0_byp", K_RD, 0, 32'd0);
    push("t3_r0_busy", K_BUSY, 0, 32'd0);
    settle();
    edge_(); idle();
    push("t3_r0", K_RD, 0, 32'd0);
    push("t3_r0_nb", K_RDNB, 0, 32'd0);
    push("t3_busy", K_BUSY, 0, 32'd0);
    push("t3_cnt", K_CNT, 0, 32'd0);
    settle();

    // 4: reservations, reserve beats same-cycle write, write clears busy
    rsv_en = 1'b1; rsv_addr = 5'd3;
    edge_();
    rsv_addr = 5'd7;
    edge_(); idle();
    rd_addr = {5'd7, 5'd3};
    push("t4_busy3", K_BUSY, 0, 32'd1);
    push("t4_busy7", K_BUSY, 1, 32'd1);
    push("t4_cnt2", K_CNT, 0, 32'd2);
    settle();
    edge_();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h33};
    rsv_en = 1'b1; rsv_addr = 5'd3;
    push("t4_byp33", K_RD, 0, 32'h33);
    push("t4_mask3", K_BUSY, 0, 32'd0);
    push("t4_busy7b", K_BUSY, 1, 32'd1);
    settle();
    edge_(); idle();
    push("t4_still3", K_BUSY, 0, 32'd1);
    push("t4_cnt2b", K_CNT, 0, 32'd2);
    push("t4_r3", K_RD, 0, 32'h33);
    settle();
    edge_();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'd0, 32'h77};
    edge_(); idle();
    push("t4_clr7", K_BUSY, 1, 32'd0);
    push("t4_cnt1", K_CNT, 0, 32'd1);
    push("t4_r7", K_RD, 1, 32'h77);
    settle();

    // 5: mid-cycle reset drops reservations and data
    edge_();
    rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr = {5'd5, 5'd9};
    edge_(); idle();
    push("t5_cnt2", K_CNT, 0, 32'd2);
    push("t5_busy9", K_BUSY, 0, 32'd1);
    push("t5_r5", K_RD, 1, 32'h5555);
    settle();
    reset = 1'b1;
    #1;
    push("t5_rst_busy9", K_BUSY, 0, 32'd0);
    push("t5_rst_cnt", K_CNT, 0, 32'd0);
    push("t5_rst_r9", K_RD, 0, 32'd0);
    push("t5_rst_r5", K_RD, 1, 32'd0);
    drain();
    #1 reset = 1'b0;
    edge_();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'd0, 32'h66};
    rsv_en = 1'b1; rsv_addr = 5'd10;
    edge_(); idle();
    push("t5_cnt1", K_CNT, 0, 32'd1);
    settle();
    edge_();
    clr = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'd0, 32'd1};
    rsv_en = 1'b1; rsv_addr = 5'd11; rd_addr = {5'd6, 5'd4};
    push("t5_clr_nobyp", K_RD, 0, 32'd0);
    push("t5_clr_r6old", K_RD, 1, 32'h66);
    settle();
    edge_(); idle();
    rd_addr = {5'd11, 5'd4};
    push("t5_r4", K_RD, 0, 32'd0);
    push("t5_busy11", K_BUSY, 1, 32'd0);
    push("t5_cnt0", K_CNT, 0, 32'd0);
    settle();
    rd_addr = {5'd10, 5'd6};
    push("t5_r6", K_RD, 0, 32'd0);
    push("t5_busy10", K_BUSY, 1, 32'd0);
    #1 drain();

    // 6: non-bypass build returns the old value in the write cycle
    edge_();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd2}; wr_data = {32'd0, 32'h1234};
    rd_addr = {5'd0, 5'd2};
    push("t6_nb_old", K_RDNB, 0, 32'd0);
    push("t6_byp", K_RD, 0, 32'h1234);
    settle();
    edge_(); idle();
    push("t6_nb_new", K_RDNB, 0, 32'h1234);
    push("t6_new", K_RD, 0, 32'h1234);
    settle();

    // random traffic over a small address window against a reference model
    foreach (mem_m[i]) begin mem_m[i] = '0; busy_m[i] = 1'b0; end
    mem_m[2] = 32'h1234;
    for (int n = 0; n < 80; n++) begin
      edge_();
      w0 = 5'($urandom_range(0, 7)); w1 = 5'($urandom_range(0, 7));
      d0 = $urandom; d1 = $urandom;
      wr_en = 2'($urandom);
      wr_addr = {w1, w0}; wr_data = {d1, d0};
      rsv_en = 1'($urandom); rsv_addr = 5'($urandom_range(0, 7));
      a0 = 5'($urandom_range(0, 7)); a1 = 5'($urandom_range(0, 7));
      rd_addr = {a1, a0};
      for (int r = 0; r < 2; r++) begin
        logic [4:0] a;
        a = (r == 0) ? a0 : a1;
        e = mem_m[a]; hit = 1'b0;
        if (wr_en[0] && w0 == a) begin e = d0; hit = 1'b1; end
        if (wr_en[1] && w1 == a) begin e = d1; hit = 1'b1; end
        if (a == 5'd0) e = '0;
        push("rnd_rd", K_RD, r, e);
        push("rnd_rdnb", K_RDNB, r, (a == 5'd0) ? 32'd0 : mem_m[a]);
        push("rnd_busy", K_BUSY, r, {31'd0, busy_m[a] && !hit});
      end
      settle();
      if (wr_en[0] && w0 != 5'd0) mem_m[w0] = d0;
      if (wr_en[1] && w1 != 5'd0) mem_m[w1] = d1;
      if (wr_en[0]) busy_m[w0] = 1'b0;
      if (wr_en[1]) busy_m[w1] = 1'b0;
      if (rsv_en && rsv_addr != 5'd0) busy_m[rsv_addr] = 1'b1;
      c = 0;
      foreach (busy_m[i]) c += int'(busy_m[i]);
      push("rnd_cnt", K_CNT, 0, 32'(c));
    end
    edge_(); idle();
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
